// File: rtl/serial_transmitter.sv
// ---------------------------------------------------------------------------
// serial_transmitter
//
// Sends one configuration byte per valid/ready handshake over a two-wire
// SCL/SDA link: START, eight data bits MSB first, an ACK slot in which SDA
// is released so the receiver can pull it low, then STOP. The result of the
// ACK slot is reported on ack_ok alongside a one-cycle done pulse.
//
// Parameters
//   HALF_PERIOD : clk cycles per SCL half-period (>= 1)
//   GAP         : idle clk cycles after a frame before the next byte is taken
//
// Ports
//   clk        in   single rising-edge clock
//   reset      in   synchronous, active-high
//   tx_valid   in   byte offered
//   tx_data    in   byte to send, bit 7 first
//   tx_ready   out  byte can be accepted this cycle
//   SCL        out  serial clock
//   SDA_Out    out  driven SDA value
//   SDA_Enable out  1 = SDA released (receiver may drive), 0 = SDA_Out drives
//   SDA_In     in   resolved SDA line, sampled at the end of the ACK slot
//   done       out  one-cycle pulse when a frame completes
//   ack_ok     out  1 = last frame was acknowledged; updates with done
// ---------------------------------------------------------------------------
module serial_transmitter #(
  parameter int HALF_PERIOD = 1,
  parameter int GAP         = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       SCL,
  output logic       SDA_Out,
  output logic       SDA_Enable,
  input  logic       SDA_In,
  output logic       done,
  output logic       ack_ok
);

  localparam int PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [PW-1:0] PhaseLast = PW'(HALF_PERIOD - 1);
  localparam logic [GW-1:0] GapLoad   = GW'(GAP);

  typedef enum logic [2:0] {
    IDLE, START, BIT_LO, BIT_HI, ACK_LO, ACK_HI, STOP_LO, STOP_HI
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [PW-1:0]   r_phase;
  logic [2:0]      r_bitCnt;
  logic [7:0]      r_shift;
  logic [GW-1:0]   r_gap;
  logic            r_ackSample;
  logic            r_scl;
  logic            r_sdaOut;
  logic            r_sdaEn;
  logic            r_done;
  logic            r_ackOk;
  logic            r_ready;

  logic            w_phaseEnd;
  logic            w_accept;
  logic [7:0]      w_nextShift;
  logic [GW-1:0]   w_nextGap;
  logic            w_nextScl;
  logic            w_nextSdaOut;
  logic            w_nextSdaEn;
  logic            w_nextDone;
  logic            w_nextReady;

  // A phase ends on the last of its HALF_PERIOD cycles. r_ready is only ever
  // high in IDLE, so a handshake can never land in the middle of a frame.
  assign w_phaseEnd = (r_phase == PhaseLast);
  assign w_accept   = tx_valid & r_ready;

  // r_ready sits at 1 through reset because IDLE with an empty gap counter
  // is ready; gating it with the reset input keeps tx_ready low while reset
  // is held and lets it rise in the very first cycle after release.
  assign tx_ready   = r_ready & ~reset;
  assign SCL        = r_scl;
  assign SDA_Out    = r_sdaOut;
  assign SDA_Enable = r_sdaEn;
  assign done       = r_done;
  assign ack_ok     = r_ackOk;

  // State register plus every registered output. The outputs are loaded from
  // the decode of the next state, so they line up with r_state exactly while
  // still coming straight out of flops. Reset mid-frame drops the frame
  // without a done pulse and clears the acknowledge result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_phase     <= '0;
      r_bitCnt    <= '0;
      r_shift     <= '0;
      r_gap       <= '0;
      r_ackSample <= 1'b0;
      r_scl       <= 1'b1;
      r_sdaOut    <= 1'b1;
      r_sdaEn     <= 1'b0;
      r_done      <= 1'b0;
      r_ackOk     <= 1'b0;
      r_ready     <= 1'b1;
    end else begin
      r_state  <= w_nextState;
      r_phase  <= (r_state == IDLE || w_phaseEnd) ? '0 : r_phase + PW'(1);
      r_shift  <= w_nextShift;
      r_gap    <= w_nextGap;
      r_scl    <= w_nextScl;
      r_sdaOut <= w_nextSdaOut;
      r_sdaEn  <= w_nextSdaEn;
      r_done   <= w_nextDone;
      r_ready  <= w_nextReady;
      if (w_accept) begin
        r_bitCnt <= '0;
      end else if (r_state == BIT_HI && w_phaseEnd) begin
        r_bitCnt <= r_bitCnt + 3'd1;
      end
      if (r_state == ACK_HI && w_phaseEnd) begin
        r_ackSample <= (SDA_In === 1'b0);
      end
      if (w_nextDone) begin
        r_ackOk <= r_ackSample;
      end
    end
  end

  // Next-state logic. Every non-idle state lasts one phase; the bit counter
  // reaching 7 at the end of BIT_HI means all eight bits have gone out.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept)   w_nextState = START;
      START:   if (w_phaseEnd) w_nextState = BIT_LO;
      BIT_LO:  if (w_phaseEnd) w_nextState = BIT_HI;
      BIT_HI:  if (w_phaseEnd) w_nextState = (r_bitCnt == 3'd7) ? ACK_LO : BIT_LO;
      ACK_LO:  if (w_phaseEnd) w_nextState = ACK_HI;
      ACK_HI:  if (w_phaseEnd) w_nextState = STOP_LO;
      STOP_LO: if (w_phaseEnd) w_nextState = STOP_HI;
      STOP_HI: if (w_phaseEnd) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath next values. The byte is latched on the handshake and shifted
  // left as each BIT_HI phase closes, so bit 7 of the shift register is
  // always the bit currently on the wire. The gap counter is loaded as the
  // frame finishes and drains while idle.
  always_comb begin
    w_nextShift = r_shift;
    w_nextGap   = r_gap;
    if (w_accept) begin
      w_nextShift = tx_data;
    end else if (r_state == BIT_HI && w_phaseEnd) begin
      w_nextShift = {r_shift[6:0], 1'b0};
    end
    if (r_state == STOP_HI && w_phaseEnd) begin
      w_nextGap = GapLoad;
    end else if (r_state == IDLE && r_gap != '0) begin
      w_nextGap = r_gap - GW'(1);
    end
  end

  // Output decode of the state being entered. SDA only moves while SCL is
  // low, except for the START fall and STOP rise that happen with SCL high.
  // In the ACK slot the line is released and SDA_Out is parked high.
  always_comb begin
    w_nextScl    = 1'b1;
    w_nextSdaOut = 1'b1;
    w_nextSdaEn  = 1'b0;
    w_nextDone   = (r_state == STOP_HI) && w_phaseEnd;
    w_nextReady  = (w_nextState == IDLE) && (w_nextGap == '0);
    case (w_nextState)
      START: begin
        w_nextSdaOut = 1'b0;
      end
      BIT_LO: begin
        w_nextScl    = 1'b0;
        w_nextSdaOut = w_nextShift[7];
      end
      BIT_HI: begin
        w_nextSdaOut = w_nextShift[7];
      end
      ACK_LO: begin
        w_nextScl   = 1'b0;
        w_nextSdaEn = 1'b1;
      end
      ACK_HI: begin
        w_nextSdaEn = 1'b1;
      end
      STOP_LO: begin
        w_nextScl    = 1'b0;
        w_nextSdaOut = 1'b0;
      end
      STOP_HI: begin
        w_nextSdaOut = 1'b0;
      end
      default: begin
        w_nextScl    = 1'b1;
        w_nextSdaOut = 1'b1;
      end
    endcase
  end

endmodule
